// File: rtl/way_allocator_if.sv
// Request/response bundle between the hit/miss logic and the way allocator.
// master: lookup/miss side that issues touches and allocations.
// slave:  the way allocator itself.
interface way_allocator_if #(
    parameter int S_BITS = 4,
    parameter int W      = 2,
    parameter int A      = 4
);
    logic              flush;
    logic              ready;
    logic              touch_en;
    logic [S_BITS-1:0] touch_set;
    logic [W-1:0]      touch_way;
    logic              alloc_req;
    logic [S_BITS-1:0] alloc_set;
    logic [A-1:0]      way_valid;
    logic              alloc_ack;
    logic [W-1:0]      alloc_way;
    logic              alloc_evict;

    modport master (
        output flush, touch_en, touch_set, touch_way, alloc_req, alloc_set, way_valid,
        input  ready, alloc_ack, alloc_way, alloc_evict
    );

    modport slave (
        input  flush, touch_en, touch_set, touch_way, alloc_req, alloc_set, way_valid,
        output ready, alloc_ack, alloc_way, alloc_evict
    );
endinterface

// File: rtl/way_allocator.sv
// Way allocator: picks the fill way on a cache miss (first invalid way, else
// tree pseudo-LRU victim) and maintains per-set tree-PLRU state from hit
// touches and its own allocations.
//
// Optional build macro WAY_ALLOCATOR_STATS_EN adds saturating allocation and
// eviction counters (alloc_count / evict_count).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | clearing the PLRU tree of one set per cycle; requests ignored
// ST_IDLE | ready; touches and allocations accepted every cycle
module way_allocator #(
    parameter int i_size   = 32,
    parameter int c_size   = 12,
    parameter int d_size   = 6,
    parameter int a_size   = 4,
    parameter int protocol = 2,
    localparam int W       = $clog2(a_size),
    localparam int S_BITS  = c_size - d_size - W,
    localparam int NSETS   = 2 ** S_BITS,
    localparam int T       = a_size - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    way_allocator_if.slave  bus
`ifdef WAY_ALLOCATOR_STATS_EN
    ,
    output logic [31:0]     alloc_count,
    output logic [31:0]     evict_count
`endif
);

    // Reject geometries the tree walk cannot represent.
    if (a_size < 2 || (a_size & (a_size - 1)) != 0 || i_size < c_size ||
        c_size <= d_size + W || protocol < 1) begin : g_param_check
        $error("way_allocator: unsupported parameter combination");
    end

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [S_BITS-1:0] sweep_cnt;
    logic              sweep_we;
    logic              ready;

    logic [T-1:0]      plru [NSETS];

    logic              touch_go;
    logic              alloc_go;
    logic              same_set;
    logic [T-1:0]      touch_tree;
    logic [T-1:0]      alloc_base;
    logic [T-1:0]      alloc_tree;
    logic              all_valid;
    logic [W-1:0]      first_free;
    logic [W-1:0]      victim;
    logic [W-1:0]      pick_way;

    // Follow the node bits from the root down to a leaf; bit 0 means the
    // victim lies in the left subtree.
    function automatic logic [W-1:0] plru_victim(input logic [T-1:0] tree);
        int           node;
        logic [T-1:0] sh;
        node = 0;
        for (int lvl = 0; lvl < W; lvl++) begin
            sh   = tree >> node;
            node = 2 * node + 1 + int'(sh[0]);
        end
        return W'(node - T);
    endfunction

    // Make every node on the path to 'way' point away from it.
    function automatic logic [T-1:0] plru_touch(input logic [T-1:0] tree,
                                                input logic [W-1:0] way);
        int           node;
        logic [W-1:0] wsh;
        logic         b;
        logic [T-1:0] res;
        res  = tree;
        node = 0;
        for (int lvl = 0; lvl < W; lvl++) begin
            wsh  = way >> (W - 1 - lvl);
            b    = wsh[0];
            res  = (res & ~(T'(1) << node)) | (T'(!b) << node);
            node = 2 * node + 1 + int'(b);
        end
        return res;
    endfunction

    // FSM state register and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end else if (bus.flush) begin
                sweep_cnt <= '0;
            end
        end
    end

    // FSM next-state: sweep ends after the last set is cleared; flush restarts it.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (sweep_cnt == S_BITS'(NSETS - 1)) state_next = ST_IDLE;
            ST_IDLE: if (bus.flush)                        state_next = ST_INIT;
            default: state_next = ST_INIT;
        endcase
    end

    // FSM outputs: clear-write enable during sweep, ready once idle.
    always_comb begin
        sweep_we = 1'b0;
        ready    = 1'b0;
        case (state)
            ST_INIT: sweep_we = 1'b1;
            ST_IDLE: ready    = 1'b1;
            default: sweep_we = 1'b1;
        endcase
    end

    assign bus.ready = ready;
    assign touch_go  = bus.touch_en  & ready;
    assign alloc_go  = bus.alloc_req & ready;
    assign same_set  = touch_go && (bus.touch_set == bus.alloc_set);
    assign all_valid = &bus.way_valid;

    // Lowest-index invalid way.
    always_comb begin
        first_free = '0;
        for (int i = a_size - 1; i >= 0; i--) begin
            if (!bus.way_valid[i]) first_free = W'(i);
        end
    end

    // Victim selection sees a same-cycle touch to the same set before choosing.
    always_comb begin
        touch_tree = plru_touch(plru[bus.touch_set], bus.touch_way);
        alloc_base = same_set ? touch_tree : plru[bus.alloc_set];
        victim     = plru_victim(alloc_base);
        pick_way   = all_valid ? victim : first_free;
        alloc_tree = plru_touch(alloc_base, pick_way);
    end

    // PLRU array: no reset; the sweep clears it. When touch and alloc share a
    // set, alloc_tree already contains the touch, so the later write wins.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            plru[sweep_cnt] <= '0;
        end else begin
            if (touch_go) plru[bus.touch_set] <= touch_tree;
            if (alloc_go) plru[bus.alloc_set] <= alloc_tree;
        end
    end

    // Allocation response: one-cycle ack, way/evict held between acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alloc_ack   <= 1'b0;
            bus.alloc_way   <= '0;
            bus.alloc_evict <= 1'b0;
        end else begin
            bus.alloc_ack <= alloc_go;
            if (alloc_go) begin
                bus.alloc_way   <= pick_way;
                bus.alloc_evict <= all_valid;
            end
        end
    end

`ifdef WAY_ALLOCATOR_STATS_EN
    // Saturating allocation / eviction counters, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_count <= '0;
            evict_count <= '0;
        end else if (bus.flush) begin
            alloc_count <= '0;
            evict_count <= '0;
        end else if (bus.alloc_ack) begin
            if (alloc_count != 32'hFFFF_FFFF) alloc_count <= alloc_count + 32'd1;
            if (bus.alloc_evict && evict_count != 32'hFFFF_FFFF)
                evict_count <= evict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_way_allocator.sv
// Self-checking bench for way_allocator: reset/sweep timing, directed vector
// table, flush sequence, and randomized traffic against a PLRU reference model.
module tb_way_allocator;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    way_allocator_if #(.S_BITS(4), .W(2), .A(4)) bus ();

`ifdef WAY_ALLOCATOR_STATS_EN
    logic [31:0] alloc_count;
    logic [31:0] evict_count;
`endif

    way_allocator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef WAY_ALLOCATOR_STATS_EN
        ,
        .alloc_count(alloc_count),
        .evict_count(evict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       te;
        logic [3:0] ts;
        logic [1:0] tw;
        logic       ar;
        logic [3:0] aset;
        logic [3:0] vv;
        logic       ack;
        logic [1:0] way;
        logic       ev;
    } vec_t;

    vec_t vecs [14];

    // Reference PLRU model: per set, root bit plus one bit per half.
    // Bit value 0 = victim on the left.
    int mt [16][3];
    int last_way;
    int last_ev;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic te, input logic [3:0] ts, input logic [1:0] tw,
                         input logic ar, input logic [3:0] aset, input logic [3:0] vv);
        bus.touch_en  = te;
        bus.touch_set = ts;
        bus.touch_way = tw;
        bus.alloc_req = ar;
        bus.alloc_set = aset;
        bus.way_valid = vv;
    endtask

    function automatic int m_victim(input int s);
        int h;
        h = mt[s][0];
        return 2 * h + mt[s][1 + h];
    endfunction

    task automatic m_access(input int s, input int w);
        mt[s][0]         = (w >= 2) ? 0 : 1;
        mt[s][1 + w / 2] = (w % 2 == 1) ? 0 : 1;
    endtask

    task automatic m_clear();
        for (int s = 0; s < 16; s++)
            for (int b = 0; b < 3; b++) mt[s][b] = 0;
    endtask

    // Counts cycles until ready rises, requiring no ack meanwhile.
    task automatic wait_ready(input string name, input bit spam);
        int n;
        n = 0;
        while (!bus.ready && n < 40) begin
            if (spam) drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                            2'($urandom_range(0, 3)), 1'b1, 4'($urandom_range(0, 15)), 4'hF);
            tick();
            n++;
            chk({name, "_ack_low"}, int'(bus.alloc_ack), 0);
        end
        drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 4'hF);
        chk({name, "_sweep_len"}, n, 16);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 4'hF);

        vecs[0]  = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd3, 4'b1011, 1'b1, 2'd2, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 4'b1111, 1'b1, 2'd0, 1'b1};
        vecs[2]  = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 4'b1111, 1'b1, 2'd2, 1'b1};
        vecs[3]  = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 4'b1111, 1'b1, 2'd1, 1'b1};
        vecs[4]  = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 4'b1111, 1'b1, 2'd3, 1'b1};
        vecs[5]  = '{1'b1, 4'd7, 2'd0, 1'b1, 4'd7, 4'b1111, 1'b1, 2'd2, 1'b1};
        vecs[6]  = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd7, 4'b1111, 1'b1, 2'd1, 1'b1};
        vecs[7]  = '{1'b1, 4'd1, 2'd0, 1'b1, 4'd2, 4'b1111, 1'b1, 2'd0, 1'b1};
        vecs[8]  = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd1, 4'b1111, 1'b1, 2'd2, 1'b1};
        vecs[9]  = '{1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 4'b1111, 1'b0, 2'd2, 1'b1};
        vecs[10] = '{1'b1, 4'd4, 2'd3, 1'b0, 4'd0, 4'b1111, 1'b0, 2'd2, 1'b1};
        vecs[11] = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd4, 4'b1111, 1'b1, 2'd0, 1'b1};
        vecs[12] = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd6, 4'b0000, 1'b1, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 4'd0, 2'd0, 1'b1, 4'd6, 4'b0111, 1'b1, 2'd3, 1'b0};

        // Reset values, then abort the sweep midway with a second reset.
        repeat (3) tick();
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_ack", int'(bus.alloc_ack), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mid_init_ready", int'(bus.ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rerst_ready", int'(bus.ready), 0);
        wait_ready("reset", 1'b0);
        chk("ready_up", int'(bus.ready), 1);

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].te, vecs[i].ts, vecs[i].tw, vecs[i].ar, vecs[i].aset, vecs[i].vv);
            tick();
            chk($sformatf("vec%0d_ack", i), int'(bus.alloc_ack), int'(vecs[i].ack));
            chk($sformatf("vec%0d_way", i), int'(bus.alloc_way), int'(vecs[i].way));
            chk($sformatf("vec%0d_evict", i), int'(bus.alloc_evict), int'(vecs[i].ev));
        end
        drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 4'hF);
        tick();
        chk("idle_ack", int'(bus.alloc_ack), 0);
`ifdef WAY_ALLOCATOR_STATS_EN
        chk("stat_alloc", int'(alloc_count), 12);
        chk("stat_evict", int'(evict_count), 9);
`endif

        // Flush with a same-cycle allocation that must still be served.
        bus.flush = 1'b1;
        drive(1'b0, 4'd0, 2'd0, 1'b1, 4'd9, 4'hF);
        tick();
        bus.flush = 1'b0;
        chk("flush_ack", int'(bus.alloc_ack), 1);
        chk("flush_way", int'(bus.alloc_way), 0);
        chk("flush_evict", int'(bus.alloc_evict), 1);
        chk("flush_ready", int'(bus.ready), 0);
`ifdef WAY_ALLOCATOR_STATS_EN
        chk("flush_stat_alloc", int'(alloc_count), 0);
        chk("flush_stat_evict", int'(evict_count), 0);
`endif
        wait_ready("flush", 1'b1);
        m_clear();
        last_way = 0;
        last_ev  = 1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic       te, ar;
            logic [3:0] ts, aset, vv;
            logic [1:0] tw;
            int         exp_ack;
            te   = 1'($urandom_range(0, 1));
            ar   = 1'($urandom_range(0, 3) != 0);
            ts   = 4'($urandom_range(0, 3));
            aset = 4'($urandom_range(0, 3));
            tw   = 2'($urandom_range(0, 3));
            vv   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            drive(te, ts, tw, ar, aset, vv);
            if (te) m_access(int'(ts), int'(tw));
            exp_ack = 0;
            if (ar) begin
                exp_ack = 1;
                if (vv != 4'hF) begin
                    last_ev = 0;
                    for (int k = 3; k >= 0; k--) if (!vv[k]) last_way = k;
                end else begin
                    last_ev  = 1;
                    last_way = m_victim(int'(aset));
                end
                m_access(int'(aset), last_way);
            end
            tick();
            chk("rnd_ready", int'(bus.ready), 1);
            chk("rnd_ack", int'(bus.alloc_ack), exp_ack);
            chk("rnd_way", int'(bus.alloc_way), last_way);
            chk("rnd_evict", int'(bus.alloc_evict), last_ev);
        end

        // Asynchronous reset clears outputs without waiting for an edge.
        drive(1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 4'b0111);
        tick();
        chk("pre_rst_way", int'(bus.alloc_way), 3);
        drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ready", int'(bus.ready), 0);
        chk("async_ack", int'(bus.alloc_ack), 0);
        chk("async_way", int'(bus.alloc_way), 0);
        chk("async_evict", int'(bus.alloc_evict), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/way_allocator.md
Name: way_allocator

Overview:
- Fill-side companion to the tag-match block selector in the set-associative cache.
- On a miss, picks the way of the indexed set that receives the new line:
  - first invalid way if one exists;
  - otherwise the tree pseudo-LRU victim.
- Keeps per-set tree-PLRU state, updated by hit "touches" from the lookup path and by its own allocations.
- Sits between the hit/miss logic and the tag/data array write port.

Parameters:
- i_size, 32, address width in bits
- c_size, 12, log2 of cache capacity in bytes
- d_size, 6, log2 of line size in bytes
- a_size, 4, associativity (power of two, >= 2)
- protocol, 2, MESI state bits per line (carried for consistency; not used internally)
- Derived: S_BITS = c_size - d_size - $clog2(a_size); NSETS = 2**S_BITS; W = $clog2(a_size); tree bits per set = a_size-1

Ports:
- clk  input  1  clock; rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  restart PLRU-state clear sweep
- ready  output  1  high when touch/alloc requests are accepted
- touch_en  input  1  hit on touch_set/touch_way; mark way most-recently used
- touch_set  input  S_BITS  set index of hit
- touch_way  input  W  way that hit
- alloc_req  input  1  miss; allocate a way in alloc_set
- alloc_set  input  S_BITS  set index of miss
- way_valid  input  a_size  bit n = 1 when way n MESI state != I
- alloc_ack  output  1  one-cycle pulse: alloc_way/alloc_evict valid
- alloc_way  output  W  chosen way
- alloc_evict  output  1  1 = chosen way held a valid line (writeback check needed)

Behaviour:
- Reset (async, rst_n low):
  - ready=0, alloc_ack=0, alloc_way=0, alloc_evict=0.
  - FSM -> INIT, sweep counter=0.
  - PLRU array is not reset asynchronously.
- FSM states:
  - INIT: each cycle write 0 to tree bits of set[counter], counter++.
  - Leaving INIT: after writing set NSETS-1 -> IDLE; ready=1 from the next cycle. The sweep takes NSETS cycles.
  - IDLE: flush=1 -> INIT, counter=0, ready drops the following cycle.
  - A request in the same cycle as flush is still processed.
  - touch_en/alloc_req while ready=0 are ignored; no ack is generated.
- Tree encoding:
  - Heap nodes: node 0 is the root; children of node n are 2n+1 and 2n+2; leaves map to ways 0..a_size-1 left to right.
  - Bit 0 = victim in the lower (left) half.
  - Victim walk: follow the bits from the root.
  - Access to way w sets every node on w's path to point away from w.
- Allocation choice:
  - If way_valid != all ones: alloc_way = lowest-index 0 bit, alloc_evict=0.
  - Else: alloc_way = PLRU victim, alloc_evict=1.
  - The chosen way is then marked accessed (tree updated).
- Latency:
  - alloc_req sampled at edge N; alloc_ack=1 with way/evict in cycle N+1 for exactly one cycle.
  - Outputs hold their last value while ack=0.
  - alloc_req may be held high every cycle: one allocation and one ack per cycle.
- Array timing: state read combinationally, written at clock edge. A request in cycle N+1 sees all updates from cycle N.
- Simultaneous touch and alloc:
  - Same set: touch applied first; victim computed from the touched state; alloc update applied on top; one write.
  - Different sets: both sets written at the same edge.
- Width rules:
  - touch_way/alloc_way are W bits; all values are legal because a_size is a power of two.
  - Set indices are S_BITS bits with no wrap logic.

Optional Feature:
- Macro: WAY_ALLOCATOR_STATS_EN
- Defined:
  - Adds outputs alloc_count[31:0] and evict_count[31:0].
  - alloc_count increments on each alloc_ack; evict_count on each ack with alloc_evict=1.
  - Both saturate at 32'hFFFF_FFFF and clear on rst_n low and on flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then wait -> ready=0 for exactly 16 cycles after rst_n rises, then 1; alloc_ack stays 0 throughout.
- Set 3, way_valid=4'b1011, alloc_req -> next cycle alloc_ack=1, alloc_way=2, alloc_evict=0.
- Set 5, way_valid=4'b1111, back-to-back alloc_req x4 from cleared state -> alloc_way sequence 0,2,1,3, each alloc_evict=1, four consecutive ack pulses.
- Set 7 cleared; touch way 0 and alloc (way_valid=4'b1111) in the same cycle -> alloc_way=2; next alloc -> way 1.
- touch set 1 way 0 with alloc set 2 same cycle (way_valid all 1) -> alloc_way=0; next alloc on set 1 -> way 2.
- Mid-INIT: assert rst_n low; mid-IDLE: assert flush -> ready drops, sweep restarts from 0, requests ignored until ready; with WAY_ALLOCATOR_STATS_EN, counters read 0 after flush.
